// File: rtl/approx_adder_1_if.sv
// Operand/result bus of the registered lower-part-OR approximate adder.
// Monitor signals exist only when APPROX_ADDER_ERROR_MON_EN is defined.
interface approx_adder_1_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH:0]   s;
`ifdef APPROX_ADDER_ERROR_MON_EN
  logic [WIDTH:0]   exact_sum;
  logic             err;
  logic [WIDTH:0]   err_mag;
  logic [31:0]      err_count;

  modport master (output in_valid, a, b,
                  input  out_valid, s, exact_sum, err, err_mag, err_count);
  modport slave  (input  in_valid, a, b,
                  output out_valid, s, exact_sum, err, err_mag, err_count);
`else
  modport master (output in_valid, a, b, input  out_valid, s);
  modport slave  (input  in_valid, a, b, output out_valid, s);
`endif
endinterface

// File: rtl/approx_adder_1.sv
// Registered LOA approximate adder: low APPROX_BITS bits are a|b, upper part exact.
// Optional error monitor (exact sum, error flag/magnitude/count): APPROX_ADDER_ERROR_MON_EN.
module approx_adder_1 #(
  parameter int WIDTH       = 16,
  parameter int APPROX_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  approx_adder_1_if.slave  bus
);
  localparam int K  = APPROX_BITS;
  localparam int HW = WIDTH - K + 1;

  logic [WIDTH:0] s_comb;
  logic [WIDTH:0] s_d, s_q;
  logic           out_valid_q;

  generate
    if (K == 0) begin : g_exact
      assign s_comb = {1'b0, bus.a} + {1'b0, bus.b};
    end else if (K == WIDTH) begin : g_all_approx
      assign s_comb = {bus.a[WIDTH-1] & bus.b[WIDTH-1], bus.a | bus.b};
    end else begin : g_loa
      logic          carry;
      logic [HW-1:0] upper;
      // The only carry into the exact section is guessed from the top approximated bit pair.
      assign carry  = bus.a[K-1] & bus.b[K-1];
      assign upper  = {1'b0, bus.a[WIDTH-1:K]} + {1'b0, bus.b[WIDTH-1:K]}
                    + {{(HW-1){1'b0}}, carry};
      assign s_comb = {upper, bus.a[K-1:0] | bus.b[K-1:0]};
    end
  endgenerate

  // NOTE: always_comb assigns every output on every path, so no latch can be inferred.
  always_comb begin
    s_d = s_q;
    if (bus.in_valid) s_d = s_comb;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
    end else begin
      out_valid_q <= bus.in_valid;
      s_q         <= s_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;

`ifdef APPROX_ADDER_ERROR_MON_EN
  logic [WIDTH:0] exact_comb;
  logic [WIDTH:0] exact_d, exact_q;
  logic [31:0]    err_count_d, err_count_q;

  assign exact_comb = {1'b0, bus.a} + {1'b0, bus.b};

  always_comb begin
    exact_d     = exact_q;
    err_count_d = err_count_q;
    if (bus.in_valid) begin
      exact_d = exact_comb;
      if (exact_comb != s_comb && err_count_q != 32'hFFFF_FFFF)
        err_count_d = err_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exact_q     <= '0;
      err_count_q <= '0;
    end else begin
      exact_q     <= exact_d;
      err_count_q <= err_count_d;
    end
  end

  // Flag and magnitude derive from the two registered sums, so they follow the same update rule.
  assign bus.exact_sum = exact_q;
  assign bus.err       = (exact_q != s_q);
  assign bus.err_mag   = (exact_q > s_q) ? (exact_q - s_q) : (s_q - exact_q);
  assign bus.err_count = err_count_q;
`endif
endmodule

// File: tb/tb_approx_adder_1.sv
// Bench for approx_adder_1: three instances (APPROX_BITS = 4, 0, 16) share one stimulus
// stream and are compared against an arithmetic LOA model.
module tb_approx_adder_1;
  localparam int W = 16;
  localparam int KS [3] = '{4, 0, 16};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  approx_adder_1_if #(.WIDTH(W)) bus4  ();
  approx_adder_1_if #(.WIDTH(W)) bus0  ();
  approx_adder_1_if #(.WIDTH(W)) bus16 ();

  approx_adder_1 #(.WIDTH(W), .APPROX_BITS(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));
  approx_adder_1 #(.WIDTH(W), .APPROX_BITS(0))  dut0  (.clk(clk), .rst(rst), .bus(bus0.slave));
  approx_adder_1 #(.WIDTH(W), .APPROX_BITS(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  logic        ov [3];
  logic [W:0]  sv [3];
  assign ov[0] = bus4.out_valid;  assign sv[0] = bus4.s;
  assign ov[1] = bus0.out_valid;  assign sv[1] = bus0.s;
  assign ov[2] = bus16.out_valid; assign sv[2] = bus16.s;
`ifdef APPROX_ADDER_ERROR_MON_EN
  logic [W:0]  exs [3];
  logic        er  [3];
  logic [W:0]  em  [3];
  logic [31:0] ec  [3];
  assign exs[0] = bus4.exact_sum;  assign er[0] = bus4.err;  assign em[0] = bus4.err_mag;  assign ec[0] = bus4.err_count;
  assign exs[1] = bus0.exact_sum;  assign er[1] = bus0.err;  assign em[1] = bus0.err_mag;  assign ec[1] = bus0.err_count;
  assign exs[2] = bus16.exact_sum; assign er[2] = bus16.err; assign em[2] = bus16.err_mag; assign ec[2] = bus16.err_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: what each instance should present after the last clock edge.
  logic        exp_valid;
  logic [W:0]  exp_s   [3];
  logic [W:0]  exp_exact;
  int unsigned exp_cnt [3];

  function automatic logic [W:0] loa_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input int k);
    int unsigned ua, ub, mask, lower, carry, upper;
    ua    = 32'(a);
    ub    = 32'(b);
    mask  = (k == 0) ? 0 : ((32'd1 << k) - 1);
    lower = (ua | ub) & mask;
    carry = (k > 0) ? ((ua >> (k - 1)) & (ub >> (k - 1)) & 1) : 0;
    upper = (ua >> k) + (ub >> k) + carry;
    return (W+1)'((upper << k) | lower);
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    bus4.in_valid  = v; bus4.a  = a; bus4.b  = b;
    bus0.in_valid  = v; bus0.a  = a; bus0.b  = b;
    bus16.in_valid = v; bus16.a = a; bus16.b = b;
  endtask

  task automatic model_reset();
    exp_valid = 1'b0;
    exp_exact = '0;
    for (int i = 0; i < 3; i++) begin
      exp_s[i]   = '0;
      exp_cnt[i] = 0;
    end
  endtask

  task automatic model_clock(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_valid = v;
    if (v) begin
      exp_exact = (W+1)'(32'(a) + 32'(b));
      for (int i = 0; i < 3; i++) begin
        exp_s[i] = loa_model(a, b, KS[i]);
        if (exp_s[i] != exp_exact && exp_cnt[i] != 32'hFFFF_FFFF) exp_cnt[i]++;
      end
    end
  endtask

  task automatic test_reset();
    logic [W-1:0] a, b;
    // Held in reset from time zero.
    drive(1'b1, 16'h1234, 16'h4321);
    #2;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (ov[i] !== 1'b0 || sv[i] !== '0)
        $display("FAIL reset_hold k=%0d: out_valid=%b s=%h, required 0/0", KS[i], ov[i], sv[i]);
      else n_pass++;
    end
    @(negedge clk); rst = 1'b0; model_reset();
    // Stream a few results, then pull rst in the middle of a valid beat.
    for (int c = 0; c < 3; c++) begin
      a = 16'($urandom); b = 16'($urandom);
      drive(1'b1, a, b);
      @(posedge clk); model_clock(1'b1, a, b);
      @(negedge clk);
    end
    n_checks++;
    if (ov[0] !== 1'b1 || sv[0] !== exp_s[0])
      $display("FAIL pre_reset_stream: out_valid=%b s=%h, required 1/%h", ov[0], sv[0], exp_s[0]);
    else n_pass++;
    drive(1'b1, 16'hABCD, 16'h1357);
    #2 rst = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (ov[i] !== 1'b0 || sv[i] !== '0)
        $display("FAIL reset_async k=%0d: out_valid=%b s=%h, required 0/0", KS[i], ov[i], sv[i]);
      else n_pass++;
    end
    @(negedge clk); rst = 1'b0;
    a = 16'h0F0F; b = 16'h0808;
    drive(1'b1, a, b);
    #1;
    n_checks++;
    if (ov[0] !== 1'b0)
      $display("FAIL reset_release_early: out_valid=%b, required 0", ov[0]);
    else n_pass++;
    @(posedge clk); model_clock(1'b1, a, b);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (ov[i] !== 1'b1 || sv[i] !== exp_s[i])
        $display("FAIL reset_first_valid k=%0d: out_valid=%b s=%h, required 1/%h",
                 KS[i], ov[i], sv[i], exp_s[i]);
      else n_pass++;
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va     [5] = '{16'h0000, 16'h000F, 16'h0008, 16'hFFF0, 16'hFFFF};
    logic [W-1:0] vb     [5] = '{16'h0000, 16'h0001, 16'h0008, 16'h0010, 16'h0001};
    logic [W:0]   s4     [5] = '{17'h00000, 17'h0000F, 17'h00018, 17'h10000, 17'h0FFFF};
    logic [W:0]   exact  [5] = '{17'h00000, 17'h00010, 17'h00010, 17'h10000, 17'h10000};
    logic [W:0]   mag    [5] = '{17'd0, 17'd1, 17'd8, 17'd0, 17'd1};
    for (int t = 0; t < 5; t++) begin
      drive(1'b1, va[t], vb[t]);
      @(posedge clk); model_clock(1'b1, va[t], vb[t]);
      @(negedge clk);
      n_checks++;
      if (ov[0] !== 1'b1 || sv[0] !== s4[t])
        $display("FAIL directed_k4 #%0d: out_valid=%b s=%h, required 1/%h", t, ov[0], sv[0], s4[t]);
      else n_pass++;
      n_checks++;
      if (sv[1] !== exact[t])
        $display("FAIL directed_k0 #%0d: s=%h, required %h", t, sv[1], exact[t]);
      else n_pass++;
`ifdef APPROX_ADDER_ERROR_MON_EN
      n_checks++;
      if (exs[0] !== exact[t] || er[0] !== (mag[t] != 0) || em[0] !== mag[t])
        $display("FAIL directed_mon #%0d: exact=%h err=%b mag=%0d, required %h/%b/%0d",
                 t, exs[0], er[0], em[0], exact[t], mag[t] != 0, mag[t]);
      else n_pass++;
`endif
    end
    // All-approximate corner: low 16 bits OR, bit 16 from the top bit pair.
    drive(1'b1, 16'h8001, 16'h8100);
    @(posedge clk); model_clock(1'b1, 16'h8001, 16'h8100);
    @(negedge clk);
    n_checks++;
    if (sv[2] !== 17'h18101)
      $display("FAIL directed_k16: s=%h, required 18101", sv[2]);
    else n_pass++;
    // Idle beat: outputs must hold.
    drive(1'b0, 16'h5555, 16'hAAAA);
    @(posedge clk); model_clock(1'b0, 16'h5555, 16'hAAAA);
    @(negedge clk);
    n_checks++;
    if (ov[2] !== 1'b0 || sv[2] !== 17'h18101)
      $display("FAIL directed_hold: out_valid=%b s=%h, required 0/18101", ov[2], sv[2]);
    else n_pass++;
  endtask

  task automatic test_stream(input string name, input int n, input int valid_pct);
    logic         v;
    logic [W-1:0] a, b;
    int           sel;
    for (int c = 0; c < n; c++) begin
      v   = ($urandom_range(99) < valid_pct);
      sel = $urandom_range(7);
      a   = (sel == 0) ? 16'hFFFF : (sel == 1) ? 16'h0000 : 16'($urandom);
      b   = (sel == 2) ? 16'hFFFF : (sel == 3) ? 16'h0001 : 16'($urandom);
      drive(v, a, b);
      @(posedge clk); model_clock(v, a, b);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (ov[i] !== exp_valid || sv[i] !== exp_s[i])
          $display("FAIL %s k=%0d cyc=%0d: out_valid=%b s=%h, required %b/%h",
                   name, KS[i], c, ov[i], sv[i], exp_valid, exp_s[i]);
        else n_pass++;
`ifdef APPROX_ADDER_ERROR_MON_EN
        n_checks++;
        if (exs[i] !== exp_exact || er[i] !== (exp_exact != exp_s[i]) || ec[i] !== exp_cnt[i] ||
            em[i] !== ((exp_exact > exp_s[i]) ? exp_exact - exp_s[i] : exp_s[i] - exp_exact))
          $display("FAIL %s_mon k=%0d cyc=%0d: exact=%h err=%b mag=%h cnt=%0d, required exact=%h cnt=%0d",
                   name, KS[i], c, exs[i], er[i], em[i], ec[i], exp_exact, exp_cnt[i]);
        else n_pass++;
`endif
      end
    end
  endtask

  task automatic test_exact_k0();
    n_checks++;
    if (sv[1] !== exp_exact)
      $display("FAIL exact_k0: s=%h, required %h", sv[1], exp_exact);
    else n_pass++;
`ifdef APPROX_ADDER_ERROR_MON_EN
    n_checks++;
    if (ec[1] !== 32'd0)
      $display("FAIL exact_k0_count: err_count=%0d, required 0", ec[1]);
    else n_pass++;
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_directed();
    test_stream("back_to_back", 2000, 100);
    test_stream("random", 20000, 60);
    test_exact_k0();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
